// File: rtl/demux_pkg.sv
// Shared constants for the stream demultiplexer: per-port delivered-word
// counter width and its saturation value.
package demux_pkg;

    localparam int                CNT_W   = 8;
    localparam logic [CNT_W-1:0]  CNT_MAX = 8'd255;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with registered occupancy; the head is presented
// combinationally and forced to zero when the FIFO is empty.
module demux_fifo2 #(
    parameter int width_in = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [width_in-1:0] din,
    input  logic                pop,
    output logic [width_in-1:0] dout,
    output logic                valid,
    output logic                full
);

    logic [width_in-1:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_occ;
    logic                w_push;
    logic                w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & valid;

    // NOTE: storage is deliberately left out of reset; occupancy gates every
    // read, so stale contents are never observable and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign valid = (r_occ != 2'd0);
    assign full  = (r_occ == 2'd2);
    assign dout  = valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/demux_stream.sv
// Routes one input stream to 2**width_sel output ports, each buffered by a
// two-entry FIFO, with a saturating delivered-word counter per port.
module demux_stream
    import demux_pkg::*;
#(
    parameter int width_in  = 8,
    parameter int width_sel = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [width_in-1:0]                   in_data,
    input  logic [width_sel-1:0]                  in_sel,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [(2**width_sel)*width_in-1:0]    out_data,
    output logic [(2**width_sel)-1:0]             out_valid,
    input  logic [(2**width_sel)-1:0]             out_ready,
    output logic [(2**width_sel)*CNT_W-1:0]       out_count
);

    localparam int N = 2**width_sel;

    logic [N-1:0] w_full;
    logic [N-1:0] w_push;
    logic [N-1:0] w_pop;

    // Readiness depends only on the addressed FIFO, never on downstream ready.
    assign in_ready = ~w_full[in_sel];

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_port
            logic [CNT_W-1:0] r_count;

            assign w_push[k] = in_valid & in_ready & (in_sel == width_sel'(k));
            assign w_pop[k]  = out_valid[k] & out_ready[k];

            demux_fifo2 #(
                .width_in (width_in)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (w_push[k]),
                .din   (in_data),
                .pop   (w_pop[k]),
                .dout  (out_data[k*width_in +: width_in]),
                .valid (out_valid[k]),
                .full  (w_full[k])
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (w_pop[k]) begin
                    r_count <= sat_inc(r_count);
                end
            end

            assign out_count[k*CNT_W +: CNT_W] = r_count;
        end
    endgenerate

endmodule

// File: tb/tb_demux_stream.sv
// Randomized and directed bench for demux_stream: the driver pushes accepted
// words into per-port model queues, a negedge monitor compares and pops them.
module tb_demux_stream;

    localparam int W = 8;
    localparam int S = 3;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic [S-1:0]     in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   out_data;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*8-1:0]   out_count;

    always #5 clk = ~clk;

    demux_stream #(
        .width_in  (W),
        .width_sel (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: contents of each port's buffer in arrival order, delivered counts.
    logic [W-1:0] q [N][$];
    int           cnt [N];
    int           pend = -1;      // port receiving a word at the coming edge
    logic         exp_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            cnt[k] = 0;
        end
        pend      = -1;
        exp_ready = 1'b1;
    endfunction

    // Called just after a rising edge: applies inputs for one cycle.
    task automatic step(input logic v, input logic [S-1:0] sel,
                        input logic [W-1:0] d, input logic [N-1:0] rdy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        exp_ready = (q[int'(sel)].size() < 2);
        if (v && exp_ready) begin
            q[int'(sel)].push_back(d);
            pend = int'(sel);
        end else begin
            pend = -1;
        end
        @(posedge clk);
        #1;
        pend = -1;
    endtask

    // Monitor: compare presented outputs with the model, then retire handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [N-1:0]   e_v;
            logic [N*W-1:0] e_d;
            logic [N*8-1:0] e_c;
            e_v = '0;
            e_d = '0;
            e_c = '0;
            for (int k = 0; k < N; k++) begin
                int occ;
                occ = q[k].size() - ((pend == k) ? 1 : 0);
                if (occ > 0) begin
                    e_v[k]         = 1'b1;
                    e_d[k*W +: W]  = q[k][0];
                end
                e_c[k*8 +: 8] = 8'(cnt[k]);
            end
            check("out_valid", 64'(out_valid), 64'(e_v));
            check("out_data",  out_data, e_d);
            check("out_count", out_count, e_c);
            check("in_ready",  64'(in_ready), 64'(exp_ready));
            for (int k = 0; k < N; k++) begin
                if (e_v[k] && out_ready[k]) begin
                    void'(q[k].pop_front());
                    if (cnt[k] < 255) cnt[k]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_reset();
        #1;
        check("reset_valid", 64'(out_valid), 64'h0);
        check("reset_data",  out_data, 64'h0);
        check("reset_count", out_count, 64'h0);
        check("reset_ready", 64'(in_ready), 64'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Routing to port 3.
        step(1'b1, 3'd3, 8'hA5, 8'hFF);
        check("route_valid", 64'(out_valid), 64'h08);
        check("route_data",  64'(out_data[3*W +: W]), 64'hA5);
        step(1'b0, 3'd0, 8'h00, 8'hFF);
        check("route_count", 64'(out_count[3*8 +: 8]), 64'd1);

        // Backpressure on port 6.
        step(1'b1, 3'd6, 8'h11, 8'hBF);
        step(1'b1, 3'd6, 8'h22, 8'hBF);
        in_valid = 1'b1;
        in_sel   = 3'd6;
        in_data  = 8'h33;
        #1;
        check("bp_ready_sel6", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        in_sel   = 3'd0;
        #1;
        check("bp_ready_sel0", 64'(in_ready), 64'h1);
        check("bp_head0", 64'(out_data[6*W +: W]), 64'h11);
        step(1'b0, 3'd6, 8'h00, 8'hFF);
        check("bp_head1", 64'(out_data[6*W +: W]), 64'h22);
        step(1'b0, 3'd6, 8'h00, 8'hFF);
        check("bp_empty", 64'(out_valid[6]), 64'h0);

        // Simultaneous push and pop on port 2 at occupancy 1.
        step(1'b1, 3'd2, 8'h01, 8'h00);
        step(1'b1, 3'd2, 8'h02, 8'h04);
        check("pp_valid", 64'(out_valid[2]), 64'h1);
        check("pp_data",  64'(out_data[2*W +: W]), 64'h02);
        check("pp_ready", 64'(in_ready), 64'h1);
        step(1'b0, 3'd2, 8'h00, 8'h04);
        check("pp_drained", 64'(out_valid[2]), 64'h0);

        // Counter saturation on port 0.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'd0, 8'(i), 8'hFF);
        end
        step(1'b0, 3'd0, 8'h00, 8'hFF);
        step(1'b0, 3'd0, 8'h00, 8'hFF);
        check("sat_count", 64'(out_count[7:0]), 64'd255);

        // Random bursts.
        for (int b = 0; b < 16; b++) begin
            logic [N-1:0] bias;
            bias = N'($urandom);
            for (int c = 0; c < 30; c++) begin
                step(($urandom % 4) != 0, S'($urandom), W'($urandom),
                     N'($urandom) | (c[0] ? bias : '0));
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'd0, 8'h00, 8'hFF);
        end
        total = 0;
        for (int k = 0; k < N; k++) total += q[k].size();
        check("drain_empty", 64'(total), 64'h0);
        check("drain_valid", 64'(out_valid), 64'h0);

        // Reset mid-traffic with two words held in port 5.
        step(1'b1, 3'd5, 8'hAA, 8'hDF);
        step(1'b1, 3'd5, 8'hBB, 8'hDF);
        check("pre_rst_full", 64'(in_ready), 64'h0);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_count", out_count, 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        check("rst_data",  out_data, 64'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd5, 8'h00, 8'hFF);
        end
        check("post_rst_valid", 64'(out_valid), 64'h0);
        check("post_rst_count", out_count, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
